tl_left_seq: RTL and testbench
==============================

TL_LEFT_SEQ -- requirements
Module: tl_left_seq

Interface
REQ-001 Parameter MIN_GRN, default 4: minimum through-green dwell in cycles; legal range 1..255.
REQ-002 Parameter MAX_GRN, default 16: green dwell after which the phase yields to a waiting cross-road; legal range MIN_GRN..255.
REQ-003 Parameter YEL_CYC, default 2: yellow dwell in cycles; legal range 1..255.
REQ-004 Parameter MAX_LFT, default 6: maximum left-turn dwell in cycles; legal range 1..255.
REQ-005 Port clk, input, 1: single clock; all state updates occur on the rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port ta, input, 1: road A through-traffic sensor, 1 = vehicle present.
REQ-008 Port tb, input, 1: road B through-traffic sensor.
REQ-009 Port la, input, 1: road A left-turn lane sensor.
REQ-010 Port lb, input, 1: road B left-turn lane sensor.
REQ-011 Port light_a, output, 2: road A signal; 00 GREEN, 01 YELLOW, 10 LEFT, 11 RED.
REQ-012 Port light_b, output, 2: road B signal, same encoding.
REQ-013 Port state, output, 3: current FSM state code, for debug.

Function
REQ-014 The FSM shall have 8 states, coded 0..7: A_GRN, A_YEL, A_LFT, A_LYEL, B_GRN, B_YEL, B_LFT, B_LYEL.
REQ-015 Outputs shall be Moore, decoded from the state register only, with no combinational path from sensors to outputs.
REQ-016 Output decode: A_GRN gives light_a=00, light_b=11. A_YEL and A_LYEL give light_a=01, light_b=11. A_LFT gives light_a=10, light_b=11. B states mirror this with the roads swapped.
REQ-017 An 8-bit dwell counter cnt shall be cleared on every state change and shall otherwise increment each cycle, saturating at 255.
REQ-018 "Elapsed(N)" means cnt >= N-1, so a state exited on Elapsed(N) is visible for exactly N cycles.
REQ-019 A_GRN shall go to A_YEL when either condition holds:
- Elapsed(MIN_GRN) and ta=0, or
- Elapsed(MAX_GRN) and (tb|lb)=1.
Otherwise it shall hold.
REQ-020 A_GRN shall hold indefinitely when ta=1 and tb=lb=0.
REQ-021 A_YEL shall leave on Elapsed(YEL_CYC): to A_LFT if la=1 in that cycle, else to B_GRN.
REQ-022 A_LFT shall go to A_LYEL when la=0 or on Elapsed(MAX_LFT).
REQ-023 A_LYEL shall go to B_GRN on Elapsed(YEL_CYC).
REQ-024 B-side transitions shall mirror REQ-019..023, with ta/tb and la/lb swapped, and B_LYEL/B_YEL returning to A_GRN.
REQ-025 Sensors shall be sampled only at the clock edge that evaluates the transition; sensor changes mid-dwell shall have no other effect.
REQ-026 A sensor asserted in the same cycle that its condition is evaluated shall take effect that cycle, with no extra latency.
REQ-027 The two roads shall never both be non-RED in any cycle.
REQ-028 Every transition into a GREEN or LEFT state shall be preceded by a YELLOW state of exactly YEL_CYC cycles.
REQ-029 Illegal state codes cannot be reached; if forced, the FSM shall go to A_YEL on the next edge.

Reset
REQ-030 When reset=1 at a rising edge, the next state shall be A_GRN with cnt=0, light_a=00, light_b=11, state=000.
REQ-031 Reset shall take priority over every transition, including mid-yellow and mid-left.
REQ-032 After reset deasserts, normal operation shall resume on the first edge with reset=0, and the MIN_GRN dwell shall restart from 0.

Verification (default parameters)
REQ-033 Reset, then ta=1, tb=lb=0 for 40 cycles -> A_GRN held all 40 cycles; light_a=00, light_b=11 throughout.
REQ-034 Reset with ta=0, tb=1, la=lb=0 -> A_GRN for 4 cycles, A_YEL for 2 cycles, then B_GRN; light_b=00 at cycle 7.
REQ-035 ta=1, tb=1 held -> A_GRN for exactly 16 cycles, A_YEL for 2, B_GRN for 16, B_YEL for 2, then back to A_GRN; the period is 36 cycles.
REQ-036 Reach A_YEL with la=1, then keep la=1 -> A_LFT for 6 cycles (light_a=10), A_LYEL for 2, then B_GRN. Repeat with la dropped to 0 at left-dwell cycle 3 -> A_LFT lasts 3 cycles.
REQ-037 Assert reset during cycle 1 of B_LYEL -> next cycle state=000, light_a=00, light_b=11, cnt=0.
REQ-038 Random sensors for 10k cycles -> REQ-027 and REQ-028 hold every cycle, and no green dwell is shorter than 4 cycles.

Source files
------------

// File: rtl/tl_left_seq.sv
// Two-road traffic-light sequencer with protected left-turn phases.
// Moore FSM: the lights are registered from the next state, so sensors never reach the outputs combinationally.
module tl_left_seq #(
  parameter int unsigned MIN_GRN = 4,
  parameter int unsigned MAX_GRN = 16,
  parameter int unsigned YEL_CYC = 2,
  parameter int unsigned MAX_LFT = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ta,
  input  logic       tb,
  input  logic       la,
  input  logic       lb,
  output logic [1:0] light_a,
  output logic [1:0] light_b,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    A_GRN  = 3'd0,
    A_YEL  = 3'd1,
    A_LFT  = 3'd2,
    A_LYEL = 3'd3,
    B_GRN  = 3'd4,
    B_YEL  = 3'd5,
    B_LFT  = 3'd6,
    B_LYEL = 3'd7
  } state_t;

  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] LEFT   = 2'b10;
  localparam logic [1:0] RED    = 2'b11;

  state_t     cur;
  state_t     nxt;
  logic [7:0] cnt;

  // A state exited on elapsed(n) is visible for exactly n cycles.
  function automatic logic elapsed(input logic [7:0] c, input int unsigned n);
    return 32'(c) >= n - 32'd1;
  endfunction

  function automatic logic [1:0] light_of_a(input state_t s);
    case (s)
      A_GRN:          return GREEN;
      A_YEL, A_LYEL:  return YELLOW;
      A_LFT:          return LEFT;
      default:        return RED;
    endcase
  endfunction

  function automatic logic [1:0] light_of_b(input state_t s);
    case (s)
      B_GRN:          return GREEN;
      B_YEL, B_LYEL:  return YELLOW;
      B_LFT:          return LEFT;
      default:        return RED;
    endcase
  endfunction

  always_comb begin
    // NOTE: assign a default before the case so every path drives nxt and no latch is inferred.
    nxt = cur;
    case (cur)
      A_GRN:
        if ((elapsed(cnt, MIN_GRN) && !ta) || (elapsed(cnt, MAX_GRN) && (tb || lb)))
          nxt = A_YEL;
      A_YEL:
        if (elapsed(cnt, YEL_CYC))
          nxt = la ? A_LFT : B_GRN;
      A_LFT:
        if (!la || elapsed(cnt, MAX_LFT))
          nxt = A_LYEL;
      A_LYEL:
        if (elapsed(cnt, YEL_CYC))
          nxt = B_GRN;
      B_GRN:
        if ((elapsed(cnt, MIN_GRN) && !tb) || (elapsed(cnt, MAX_GRN) && (ta || la)))
          nxt = B_YEL;
      B_YEL:
        if (elapsed(cnt, YEL_CYC))
          nxt = lb ? B_LFT : A_GRN;
      B_LFT:
        if (!lb || elapsed(cnt, MAX_LFT))
          nxt = B_LYEL;
      B_LYEL:
        if (elapsed(cnt, YEL_CYC))
          nxt = A_GRN;
      // Unreachable with a full 3-bit encoding; a corrupted code falls back through yellow.
      default: nxt = A_YEL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur     <= A_GRN;
      cnt     <= '0;
      light_a <= GREEN;
      light_b <= RED;
    end else begin
      cur <= nxt;
      if (nxt != cur)
        cnt <= '0;
      else if (cnt != 8'hFF)
        cnt <= cnt + 8'd1;
      light_a <= light_of_a(nxt);
      light_b <= light_of_b(nxt);
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_tl_left_seq.sv
// Directed and random checks of tl_left_seq with default parameters.
// Expected state sequences are queued per phase and popped as the DUT advances.
module tb_tl_left_seq;

  localparam int MIN_GRN = 4;
  localparam int YEL_CYC = 2;

  localparam logic [2:0] A_GRN = 3'd0, A_YEL = 3'd1, A_LFT = 3'd2, A_LYEL = 3'd3;
  localparam logic [2:0] B_GRN = 3'd4, B_YEL = 3'd5, B_LFT = 3'd6, B_LYEL = 3'd7;
  localparam logic [1:0] GREEN = 2'b00, YELLOW = 2'b01, LEFT = 2'b10, RED = 2'b11;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ta = 1'b0, tb = 1'b0, la = 1'b0, lb = 1'b0;
  logic [1:0] light_a, light_b;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  logic [2:0] sb[$];

  tl_left_seq dut (
    .clk(clk), .reset(reset), .ta(ta), .tb(tb), .la(la), .lb(lb),
    .light_a(light_a), .light_b(light_b), .state(state)
  );

  always #5 clk = ~clk;

  // Light table written from the signal encoding: road A lit in codes 0..3, road B in 4..7.
  function automatic logic [1:0] exp_light(input logic [2:0] s, input logic road_b);
    logic [1:0] tbl [4];
    tbl[0] = GREEN; tbl[1] = YELLOW; tbl[2] = LEFT; tbl[3] = YELLOW;
    if (s[2] == road_b) return tbl[s[1:0]];
    return RED;
  endfunction

  function automatic logic is_green(input logic [2:0] s);
    return s == A_GRN || s == B_GRN;
  endfunction

  function automatic logic is_yellow(input logic [2:0] s);
    return s == A_YEL || s == A_LYEL || s == B_YEL || s == B_LYEL;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input logic [2:0] s, input int n);
    for (int i = 0; i < n; i++) sb.push_back(s);
  endtask

  task automatic run(input string tag, input int n);
    logic [2:0] e;
    for (int i = 0; i < n; i++) begin
      tick();
      if (sb.size() == 0) begin
        check({tag, "_sb_underflow"}, 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check({tag, "_state"}, 32'(state), 32'(e));
        check({tag, "_light_a"}, 32'(light_a), 32'(exp_light(e, 1'b0)));
        check({tag, "_light_b"}, 32'(light_b), 32'(exp_light(e, 1'b1)));
      end
    end
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    tick();
    check({tag, "_rst_state"}, 32'(state), 32'(A_GRN));
    check({tag, "_rst_light_a"}, 32'(light_a), 32'(GREEN));
    check({tag, "_rst_light_b"}, 32'(light_b), 32'(RED));
    reset = 1'b0;
  endtask

  initial begin
    logic [2:0] prev;
    int yel_run;
    int grn_run;

    // A road busy, B idle: A_GRN holds for 40 cycles.
    ta = 1; tb = 0; la = 0; lb = 0;
    do_reset("hold");
    expect_state(A_GRN, 39);
    run("hold", 39);

    // A idle, B waiting: minimum green, yellow, then B green on cycle 7.
    ta = 0; tb = 1; la = 0; lb = 0;
    do_reset("min");
    expect_state(A_GRN, 3); expect_state(A_YEL, 2); expect_state(B_GRN, 1);
    run("min", 6);

    // Both roads busy: 36-cycle alternation capped by the maximum green.
    ta = 1; tb = 1; la = 0; lb = 0;
    do_reset("max");
    expect_state(A_GRN, 15); expect_state(A_YEL, 2); expect_state(B_GRN, 16);
    expect_state(B_YEL, 2); expect_state(A_GRN, 16); expect_state(A_YEL, 1);
    run("max", 52);

    // A left turn held for the full dwell.
    ta = 0; tb = 0; la = 1; lb = 0;
    do_reset("lft_full");
    expect_state(A_GRN, 3); expect_state(A_YEL, 2); expect_state(A_LFT, 6);
    expect_state(A_LYEL, 2); expect_state(B_GRN, 1);
    run("lft_full", 14);

    // A left turn released after its third cycle.
    ta = 0; tb = 0; la = 1; lb = 0;
    do_reset("lft_short");
    expect_state(A_GRN, 3); expect_state(A_YEL, 2); expect_state(A_LFT, 3);
    run("lft_short", 8);
    la = 0;
    expect_state(A_LYEL, 2); expect_state(B_GRN, 1);
    run("lft_short", 3);

    // A busy, only a B left-turn waiting: A yields at max green, B yields at min green, B left follows.
    ta = 1; tb = 0; la = 0; lb = 1;
    do_reset("blft");
    expect_state(A_GRN, 15); expect_state(A_YEL, 2); expect_state(B_GRN, 4);
    expect_state(B_YEL, 2); expect_state(B_LFT, 1);
    run("blft", 24);

    // Reach B_LYEL, reset on its first cycle, then confirm the minimum green restarts from zero.
    ta = 0; tb = 0; la = 0; lb = 1;
    do_reset("mid_lyel");
    expect_state(A_GRN, 3); expect_state(A_YEL, 2); expect_state(B_GRN, 4);
    expect_state(B_YEL, 2); expect_state(B_LFT, 6); expect_state(B_LYEL, 1);
    run("mid_lyel", 18);
    do_reset("mid_lyel_rst");
    expect_state(A_GRN, 3); expect_state(A_YEL, 1);
    run("mid_lyel_post", 4);

    check("sb_drained", 32'(sb.size()), 32'd0);

    // Random sensors: lights exclusive, decode consistent, yellow precedes green/left, min green honoured.
    do_reset("rand");
    prev = A_GRN;
    grn_run = 1;
    yel_run = 0;
    for (int i = 0; i < 10000; i++) begin
      ta = 1'($urandom); tb = 1'($urandom); la = 1'($urandom); lb = 1'($urandom);
      tick();
      check("rand_exclusive", 32'(light_a == RED || light_b == RED), 32'd1);
      check("rand_light_a", 32'(light_a), 32'(exp_light(state, 1'b0)));
      check("rand_light_b", 32'(light_b), 32'(exp_light(state, 1'b1)));
      if (state != prev && !is_yellow(state))
        check("rand_yellow_before", 32'(yel_run), 32'(YEL_CYC));
      if (state != prev && is_green(prev))
        check("rand_min_green", 32'(grn_run >= MIN_GRN), 32'd1);
      yel_run = is_yellow(state) ? ((state == prev) ? yel_run + 1 : 1) : 0;
      grn_run = is_green(state) ? ((state == prev) ? grn_run + 1 : 1) : 0;
      prev = state;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
